// File: rtl/seq_divider_16x8.sv
// Sequential restoring divider: DIVIDEND_W / DIVISOR_W unsigned, one quotient bit per clock.
// Optional macro DIV_EARLY_EXIT_EN: finish in one cycle when dividend < divisor.
module seq_divider_16x8 #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;     // dividend shift register, fills with quotient bits
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]  prem_q, prem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    shifted;
  logic [DIVISOR_W-1:0]  diff;
  logic                  qbit;

  // The shifted partial remainder is DIVISOR_W+1 bits wide; whenever it is >= divisor the
  // true difference is < divisor, so the low DIVISOR_W bits of a modulo subtract are exact.
  assign shifted = {prem_q, dvd_q[DIVIDEND_W-1]};
  assign qbit    = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted[DIVISOR_W-1:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          prem_d = '0;
          cnt_d  = '0;
          if (divisor == '0) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (dividend < DIVIDEND_W'(divisor)) begin
            state_d = S_DONE;
            quot_d  = '0;
            rem_d   = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b0;
          end
`endif
          else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        dvd_d  = {dvd_q[DIVIDEND_W-2:0], qbit};
        prem_d = qbit ? diff : shifted[DIVISOR_W-1:0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          quot_d  = {dvd_q[DIVIDEND_W-2:0], qbit};
          rem_d   = qbit ? diff : shifted[DIVISOR_W-1:0];
          dbz_d   = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16x8.sv
// Directed and random self-checking bench for seq_divider_16x8 (honours DIV_EARLY_EXIT_EN).
module tb_seq_divider_16x8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  seq_divider_16x8 #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
  endtask

  // Accepting edge counts as cycle T; returns at the negedge of the first done cycle (or timeout).
  task automatic wait_done(output int lat);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 27'd0)
      $display("FAIL reset_state: busy=%b done=%b q=%h r=%h dbz=%b, want all zero",
               busy, done, quotient, remainder, div_by_zero);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat;
    issue(16'h03E8, 8'h07);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL basic_busy: busy=%b done=%b at T+1, want busy=1 done=0", busy, done);
    else pass_cnt++;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    $display("op 03e8/07 -> q=%h r=%h dbz=%b lat=%0d", quotient, remainder, div_by_zero, lat);
    total_cnt++;
    if (done !== 1'b1 || lat != 17 || busy !== 1'b1)
      $display("FAIL basic_latency: done=%b busy=%b lat=%0d, want done=1 busy=1 lat=17", done, busy, lat);
    else pass_cnt++;
    total_cnt++;
    if (quotient !== 16'h008E || remainder !== 8'h06 || div_by_zero !== 1'b0)
      $display("FAIL basic_result: q=%h r=%h dbz=%b, want 008e 06 0", quotient, remainder, div_by_zero);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 16'h008E || remainder !== 8'h06)
      $display("FAIL basic_hold: done=%b busy=%b q=%h r=%h, want 0 0 008e 06", done, busy, quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_extremes();
    logic [15:0] va [4] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0004};
    logic [7:0]  vb [4] = '{8'hFF, 8'h01, 8'h05, 8'h09};
    logic [15:0] eq [4] = '{16'h0101, 16'hFFFF, 16'h0000, 16'h0000};
    logic [7:0]  er [4] = '{8'h00, 8'h00, 8'h00, 8'h04};
    int          el [4] = '{17, 17, EARLY ? 1 : 17, EARLY ? 1 : 17};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i]);
      wait_done(lat);
      $display("op %h/%h -> q=%h r=%h dbz=%b lat=%0d", va[i], vb[i], quotient, remainder, div_by_zero, lat);
      total_cnt++;
      if (done !== 1'b1 || lat != el[i] || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0)
        $display("FAIL extreme_%0d: done=%b lat=%0d q=%h r=%h dbz=%b, want 1 %0d %h %h 0",
                 i, done, lat, quotient, remainder, div_by_zero, el[i], eq[i], er[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    issue(16'h1234, 8'h00);
    wait_done(lat);
    $display("op 1234/00 -> q=%h r=%h dbz=%b lat=%0d", quotient, remainder, div_by_zero, lat);
    total_cnt++;
    if (done !== 1'b1 || lat != 1 || quotient !== 16'hFFFF || remainder !== 8'h34 || div_by_zero !== 1'b1)
      $display("FAIL div_zero: done=%b lat=%0d q=%h r=%h dbz=%b, want 1 1 ffff 34 1",
               done, lat, quotient, remainder, div_by_zero);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 16'hFFFF)
      $display("FAIL div_zero_hold: done=%b dbz=%b q=%h, want 0 1 ffff", done, div_by_zero, quotient);
    else pass_cnt++;
    issue(16'h0010, 8'h04);
    wait_done(lat);
    $display("op 0010/04 -> q=%h r=%h dbz=%b lat=%0d", quotient, remainder, div_by_zero, lat);
    total_cnt++;
    if (done !== 1'b1 || lat != 17 || quotient !== 16'h0004 || remainder !== 8'h00 || div_by_zero !== 1'b0)
      $display("FAIL div_zero_clear: done=%b lat=%0d q=%h r=%h dbz=%b, want 1 17 0004 00 0",
               done, lat, quotient, remainder, div_by_zero);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    int dones = 0;
    int done_at = -1;
    issue(16'd100, 8'd3);
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 17; c++) begin
      if (done === 1'b1) begin
        dones++;
        done_at = c;
      end
      start    = (c == 5 || c == 17);
      dividend = 16'd50;
      divisor  = 8'd5;
      if (c < 17) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    $display("op 100/3 with stray starts -> q=%0d r=%0d dones=%0d at=%0d", quotient, remainder, dones, done_at);
    total_cnt++;
    if (dones != 1 || done_at != 17 || quotient !== 16'd33 || remainder !== 8'd1)
      $display("FAIL busy_ignore: dones=%0d at=%0d q=%0d r=%0d, want 1 17 33 1", dones, done_at, quotient, remainder);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL after_done_idle: done=%b busy=%b, want 0 0", done, busy);
    else pass_cnt++;
    start = 1'b1;
    dividend = 16'd50;
    divisor  = 8'd5;
    wait_done(lat);
    $display("op 50/5 at T+18 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    total_cnt++;
    if (done !== 1'b1 || lat != 17 || quotient !== 16'd10 || remainder !== 8'd0)
      $display("FAIL restart_t18: done=%b lat=%0d q=%0d r=%0d, want 1 17 10 0", done, lat, quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int dones = 0;
    issue(16'd100, 8'd3);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 27'd0)
      $display("FAIL reset_mid: busy=%b done=%b q=%h r=%h dbz=%b, want all zero",
               busy, done, quotient, remainder, div_by_zero);
    else pass_cnt++;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total_cnt++;
    if (dones != 0)
      $display("FAIL reset_no_done: dones=%0d, want 0", dones);
    else pass_cnt++;
    issue(16'd200, 8'd10);
    wait_done(lat);
    $display("op 200/10 after reset -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    total_cnt++;
    if (done !== 1'b1 || lat != 17 || quotient !== 16'd20 || remainder !== 8'd0)
      $display("FAIL reset_recover: done=%b lat=%0d q=%0d r=%0d, want 1 17 20 0", done, lat, quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] eq;
    logic [7:0]  er;
    int el;
    for (int i = 0; i < 1000; i++) begin
      a  = 16'($urandom_range(0, 65535));
      b  = 8'($urandom_range(1, 255));
      eq = a / {8'd0, b};
      er = 8'(a % {8'd0, b});
      el = (EARLY && a < {8'd0, b}) ? 1 : 17;
      issue(a, b);
      wait_done(lat);
      $display("rnd %0d: %h/%h -> q=%h r=%h lat=%0d", i, a, b, quotient, remainder, lat);
      total_cnt++;
      if (done !== 1'b1 || lat != el || quotient !== eq || remainder !== er || div_by_zero !== 1'b0
          || remainder >= b || (32'(quotient) * 32'(b) + 32'(remainder)) != 32'(a))
        $display("FAIL random_%0d: a=%h b=%h done=%b lat=%0d q=%h r=%h dbz=%b, want lat=%0d q=%h r=%h dbz=0",
                 i, a, b, done, lat, quotient, remainder, div_by_zero, el, eq, er);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
